cpcs_rx_link_ctrl: RTL and testbench

- Receive-lane bring-up and recovery sequencer for the CorePCS receive path.
- Sits in the EPCS_RxCLK domain alongside the reset synchronizer and drives the word-aligner reset (WA_RSTn) that the synchronizer consumes.
- Bring-up sequence: waits for a stable EPCS_RxVAL, pulses the word-aligner reset, waits for alignment lock with timeout and bounded retries, then declares link up.
- After link-up it monitors for loss of alignment and re-runs the sequence when needed.

---
 rtl/cpcs_rx_link_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cpcs_rx_link_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpcs_rx_link_ctrl.sv
// Receive-lane bring-up/recovery sequencer: qualifies EPCS_RxVAL, pulses WA_RSTn, waits for lock with retries.
// Optional link statistics (LINK_LOSS_CNT, LOCK_LAT) are built when CPCS_LINK_STATS_EN is defined.
module cpcs_rx_link_ctrl #(
  parameter int VAL_STABLE_CYC = 64,
  parameter int WA_RST_CYC     = 8,
  parameter int LOCK_CONFIRM   = 16,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int MAX_RETRY      = 7,
  parameter int CNT_W          = 16
) (
  input  logic             EPCS_RxCLK,
  input  logic             EPCS_RxRSTn,
  input  logic             EPCS_RxVAL,
  input  logic             ALIGNED,
  input  logic             ALIGN_ERR,
  input  logic             FORCE_REALIGN,
  output logic             WA_RSTn,
  output logic             PCS_RX_EN,
  output logic             LINK_UP,
  output logic             LINK_FAIL,
  output logic [2:0]       RETRY_CNT,
  output logic [2:0]       STATE
`ifdef CPCS_LINK_STATS_EN
  ,
  output logic [15:0]      LINK_LOSS_CNT,
  output logic [CNT_W-1:0] LOCK_LAT
`endif
);

  typedef enum logic [2:0] {
    S_WAIT_VAL  = 3'd1,
    S_WA_RST    = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_LINK      = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] VAL_LAST   = CNT_W'(VAL_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] WA_LAST    = CNT_W'(WA_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CONFIRM - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]       RETRY_MAX  = 3'(MAX_RETRY);
  localparam logic [2:0]       RETRY_LAST = 3'(MAX_RETRY - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] lock_cnt, nxt_lock;
  logic [2:0]       retry_cnt, nxt_retry;
  logic             lock_hit;

  assign STATE     = state;
  assign RETRY_CNT = retry_cnt;
  assign lock_hit  = ALIGNED && !ALIGN_ERR && (lock_cnt == LOCK_LAST);

  // Next-state and counter computation; valid-loss outranks realign requests, which outrank per-state rules.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_lock  = lock_cnt;
    nxt_retry = retry_cnt;
    if ((state != S_FAIL) && !EPCS_RxVAL) begin
      nxt_state = S_WAIT_VAL;
      nxt_cnt   = '0;
      nxt_lock  = '0;
    end else if (FORCE_REALIGN) begin
      nxt_state = EPCS_RxVAL ? S_WA_RST : S_WAIT_VAL;
      nxt_cnt   = '0;
      nxt_lock  = '0;
      nxt_retry = 3'd0;
    end else begin
      case (state)
        S_WAIT_VAL: begin
          if (cnt == VAL_LAST) begin
            nxt_state = S_WA_RST;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        S_WA_RST: begin
          if (cnt == WA_LAST) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = '0;
            nxt_lock  = '0;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          nxt_cnt = cnt + CNT_W'(1);
          if (ALIGNED && !ALIGN_ERR) begin
            nxt_lock = lock_cnt + CNT_W'(1);
          end else begin
            nxt_lock = '0;
          end
          // Lock is checked first so a lock on the final timeout cycle still succeeds.
          if (lock_hit) begin
            nxt_state = S_LINK;
            nxt_cnt   = '0;
            nxt_lock  = '0;
            nxt_retry = 3'd0;
          end else if (cnt == TO_LAST) begin
            nxt_cnt  = '0;
            nxt_lock = '0;
            if (retry_cnt >= RETRY_LAST) begin
              nxt_state = S_FAIL;
              nxt_retry = RETRY_MAX;
            end else begin
              nxt_state = S_WA_RST;
              nxt_retry = retry_cnt + 3'd1;
            end
          end else begin
            nxt_state = S_WAIT_LOCK;
          end
        end
        S_LINK: begin
          if (ALIGN_ERR || !ALIGNED) begin
            nxt_state = S_WA_RST;
            nxt_cnt   = '0;
            nxt_lock  = '0;
          end else begin
            nxt_state = S_LINK;
          end
        end
        S_FAIL: begin
          nxt_state = S_FAIL;
        end
        default: begin
          nxt_state = S_WAIT_VAL;
          nxt_cnt   = '0;
          nxt_lock  = '0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so they move with it.
  always_ff @(posedge EPCS_RxCLK or negedge EPCS_RxRSTn) begin
    if (!EPCS_RxRSTn) begin
      state         <= S_WAIT_VAL;
      cnt           <= '0;
      lock_cnt      <= '0;
      retry_cnt     <= 3'd0;
      WA_RSTn       <= 1'b0;
      PCS_RX_EN     <= 1'b0;
      LINK_UP       <= 1'b0;
      LINK_FAIL     <= 1'b0;
`ifdef CPCS_LINK_STATS_EN
      LINK_LOSS_CNT <= 16'd0;
      LOCK_LAT      <= '0;
`endif
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      lock_cnt  <= nxt_lock;
      retry_cnt <= nxt_retry;
      WA_RSTn   <= (nxt_state == S_WAIT_LOCK) || (nxt_state == S_LINK);
      PCS_RX_EN <= (nxt_state == S_LINK);
      LINK_UP   <= (nxt_state == S_LINK);
      LINK_FAIL <= (nxt_state == S_FAIL);
`ifdef CPCS_LINK_STATS_EN
      if ((state == S_LINK) && (nxt_state != S_LINK) && (LINK_LOSS_CNT != 16'hFFFF)) begin
        LINK_LOSS_CNT <= LINK_LOSS_CNT + 16'd1;
      end else begin
        LINK_LOSS_CNT <= LINK_LOSS_CNT;
      end
      if ((state == S_WAIT_LOCK) && (nxt_state == S_LINK)) begin
        LOCK_LAT <= cnt;
      end else begin
        LOCK_LAT <= LOCK_LAT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cpcs_rx_link_ctrl.sv
// Directed self-checking bench for cpcs_rx_link_ctrl using the small test-plan parameter set.
module tb_cpcs_rx_link_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       val = 1'b0;
  logic       aligned = 1'b0;
  logic       align_err = 1'b0;
  logic       force_re = 1'b0;
  logic       wa_rstn, pcs_rx_en, link_up, link_fail;
  logic [2:0] retry_cnt, state;
`ifdef CPCS_LINK_STATS_EN
  logic [15:0] link_loss_cnt;
  logic [15:0] lock_lat;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpcs_rx_link_ctrl #(
    .VAL_STABLE_CYC(4),
    .WA_RST_CYC(2),
    .LOCK_CONFIRM(3),
    .LOCK_TIMEOUT(20),
    .MAX_RETRY(2),
    .CNT_W(16)
  ) dut (
    .EPCS_RxCLK(clk),
    .EPCS_RxRSTn(rst_n),
    .EPCS_RxVAL(val),
    .ALIGNED(aligned),
    .ALIGN_ERR(align_err),
    .FORCE_REALIGN(force_re),
    .WA_RSTn(wa_rstn),
    .PCS_RX_EN(pcs_rx_en),
    .LINK_UP(link_up),
    .LINK_FAIL(link_fail),
    .RETRY_CNT(retry_cnt),
    .STATE(state)
`ifdef CPCS_LINK_STATS_EN
    ,
    .LINK_LOSS_CNT(link_loss_cnt),
    .LOCK_LAT(lock_lat)
`endif
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; val = 1'b0; aligned = 1'b0; align_err = 1'b0; force_re = 1'b0;
    #12;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL reset_state got %0d exp 1", state); end
    checks++; if (wa_rstn !== 1'b0) begin errors++; $display("FAIL reset_wa_rstn got %b exp 0", wa_rstn); end
    checks++; if ({link_up, pcs_rx_en, link_fail} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {link_up, pcs_rx_en, link_fail}); end
    checks++; if (retry_cnt !== 3'd0) begin errors++; $display("FAIL reset_retry got %0d exp 0", retry_cnt); end
    step(3);
    checks++; if (state !== 3'd1 || wa_rstn !== 1'b0) begin errors++; $display("FAIL idle_noval got state %0d wa %b exp 1 0", state, wa_rstn); end
  endtask

  task automatic test_bring_up;
    logic [2:0] exp_s [9];
    logic       exp_w [9];
    exp_s = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    val = 1'b1; aligned = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL bringup_state[%0d] got %0d exp %0d", i, state, exp_s[i]); end
      checks++; if (wa_rstn !== exp_w[i]) begin errors++; $display("FAIL bringup_wa[%0d] got %b exp %b", i, wa_rstn, exp_w[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({link_up, pcs_rx_en, link_fail} !== 3'b110) begin errors++; $display("FAIL bringup_link[%0d] got %b exp 110", i, {link_up, pcs_rx_en, link_fail}); end
      step(1);
    end
  endtask

  task automatic test_unstable_valid;
    logic       pat [8];
    logic [2:0] exp_s [8];
    pat   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_s = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      val = pat[i];
      step(1);
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL unstable_state[%0d] got %0d exp %0d", i, state, exp_s[i]); end
      checks++; if (wa_rstn !== 1'b0) begin errors++; $display("FAIL unstable_wa[%0d] got %b exp 0", i, wa_rstn); end
    end
  endtask

  task automatic test_retry_fail;
    do_reset();
    val = 1'b1; aligned = 1'b0;
    step(6);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL retry_enter_lock got %0d exp 3", state); end
    step(19);
    checks++; if (state !== 3'd3 || retry_cnt !== 3'd0) begin errors++; $display("FAIL retry_before_to got state %0d retry %0d exp 3 0", state, retry_cnt); end
    step(1);
    checks++; if (state !== 3'd2 || retry_cnt !== 3'd1) begin errors++; $display("FAIL retry_first_to got state %0d retry %0d exp 2 1", state, retry_cnt); end
    step(2);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL retry_relock got %0d exp 3", state); end
    step(20);
    checks++; if (state !== 3'd5 || retry_cnt !== 3'd2) begin errors++; $display("FAIL retry_fail got state %0d retry %0d exp 5 2", state, retry_cnt); end
    checks++; if (link_fail !== 1'b1 || wa_rstn !== 1'b0 || link_up !== 1'b0) begin errors++; $display("FAIL retry_fail_out got lf %b wa %b lu %b exp 1 0 0", link_fail, wa_rstn, link_up); end
    val = 1'b0;
    step(3);
    checks++; if (state !== 3'd5 || link_fail !== 1'b1) begin errors++; $display("FAIL fail_hold got state %0d lf %b exp 5 1", state, link_fail); end
    val = 1'b1; force_re = 1'b1;
    step(1);
    force_re = 1'b0;
    checks++; if (state !== 3'd2 || retry_cnt !== 3'd0 || link_fail !== 1'b0) begin errors++; $display("FAIL fail_force got state %0d retry %0d lf %b exp 2 0 0", state, retry_cnt, link_fail); end
  endtask

  task automatic test_valid_drop;
    step(2);
    step(20);
    checks++; if (state !== 3'd2 || retry_cnt !== 3'd1) begin errors++; $display("FAIL drop_setup got state %0d retry %0d exp 2 1", state, retry_cnt); end
    step(2);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL drop_in_lock got %0d exp 3", state); end
    val = 1'b0;
    step(1);
    checks++; if (state !== 3'd1 || wa_rstn !== 1'b0 || retry_cnt !== 3'd1) begin errors++; $display("FAIL drop got state %0d wa %b retry %0d exp 1 0 1", state, wa_rstn, retry_cnt); end
  endtask

  task automatic test_fail_force_noval;
    val = 1'b1;
    step(26);
    checks++; if (state !== 3'd5 || retry_cnt !== 3'd2) begin errors++; $display("FAIL nv_fail got state %0d retry %0d exp 5 2", state, retry_cnt); end
    val = 1'b0; force_re = 1'b1;
    step(1);
    force_re = 1'b0;
    checks++; if (state !== 3'd1 || retry_cnt !== 3'd0 || link_fail !== 1'b0) begin errors++; $display("FAIL nv_force got state %0d retry %0d lf %b exp 1 0 0", state, retry_cnt, link_fail); end
  endtask

  task automatic test_link_loss;
    do_reset();
    val = 1'b1; aligned = 1'b1;
    step(9);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL loss_up got %0d exp 4", state); end
`ifdef CPCS_LINK_STATS_EN
    checks++; if (lock_lat !== 16'd2) begin errors++; $display("FAIL lock_lat got %0d exp 2", lock_lat); end
`endif
    align_err = 1'b1;
    step(1);
    align_err = 1'b0;
    checks++; if (state !== 3'd2 || link_up !== 1'b0 || pcs_rx_en !== 1'b0 || retry_cnt !== 3'd0) begin errors++; $display("FAIL loss_err got state %0d lu %b en %b retry %0d exp 2 0 0 0", state, link_up, pcs_rx_en, retry_cnt); end
`ifdef CPCS_LINK_STATS_EN
    checks++; if (link_loss_cnt !== 16'd1) begin errors++; $display("FAIL loss_cnt1 got %0d exp 1", link_loss_cnt); end
`endif
    step(5);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL loss_relink got %0d exp 4", state); end
    aligned = 1'b0;
    step(1);
    checks++; if (state !== 3'd2 || link_up !== 1'b0) begin errors++; $display("FAIL loss_unaligned got state %0d lu %b exp 2 0", state, link_up); end
`ifdef CPCS_LINK_STATS_EN
    checks++; if (link_loss_cnt !== 16'd2) begin errors++; $display("FAIL loss_cnt2 got %0d exp 2", link_loss_cnt); end
`endif
  endtask

  task automatic test_lock_at_timeout;
    step(2);
    step(17);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL edge_wait got %0d exp 3", state); end
    aligned = 1'b1;
    step(2);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL edge_pre got %0d exp 3", state); end
    step(1);
    checks++; if (state !== 3'd4 || retry_cnt !== 3'd0 || link_up !== 1'b1) begin errors++; $display("FAIL edge_lock_wins got state %0d retry %0d lu %b exp 4 0 1", state, retry_cnt, link_up); end
`ifdef CPCS_LINK_STATS_EN
    checks++; if (lock_lat !== 16'd19) begin errors++; $display("FAIL edge_lock_lat got %0d exp 19", lock_lat); end
`endif
  endtask

  task automatic test_async_reset;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd1 || wa_rstn !== 1'b0) begin errors++; $display("FAIL async_state got state %0d wa %b exp 1 0", state, wa_rstn); end
    checks++; if ({link_up, pcs_rx_en, link_fail} !== 3'b000 || retry_cnt !== 3'd0) begin errors++; $display("FAIL async_flags got %b retry %0d exp 000 0", {link_up, pcs_rx_en, link_fail}, retry_cnt); end
`ifdef CPCS_LINK_STATS_EN
    checks++; if (link_loss_cnt !== 16'd0) begin errors++; $display("FAIL async_loss got %0d exp 0", link_loss_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_unstable_valid();
    test_retry_fail();
    test_valid_drop();
    test_fail_force_noval();
    test_link_loss();
    test_lock_at_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
